// File: rtl/alu_mc_seq.sv
// alu_mc_seq: multi-cycle ALU behind a valid/ready handshake, one op in flight.
// Simple ops (add/sub/logic/slt) complete one cycle after accept. Mul/div run an
// iterative shift-add / restoring-subtract loop, one bit per cycle, then finalise.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/op presented        in_ready   block is idle and can accept
//   A, B       operands                     ALUctr     operation code
//   out_valid  result valid, held until out_ready
//   out_ready  consumer takes result
//   Res        result (LO / quotient)       Hi         HI product / remainder, else 0
//   Zero       Res == 0                     Overfl     signed overflow for add/sub
module alu_mc_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [CTR_W-1:0] ALUctr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Res,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             Overfl
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [2:0] {StIdle, StCalc, StBusy, StFin, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CTR_W-1:0] ctr_q;
  logic [WIDTH-1:0] mag_a_q, mag_b_q;
  // acc_q: partial product high half (mul) or partial remainder (div).
  // lo_q:  multiplier shifting out / product low half (mul), dividend -> quotient (div).
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] lo_q;
  logic [CntW-1:0]  cnt_q;
  logic             qneg_q, rneg_q;
  logic [WIDTH-1:0] res_q, hi_q;
  logic             zero_q, ovfl_q;

  logic [3:0] op;
  assign op = ctr_q[3:0];

  // Simple-op datapath, evaluated on the latched operands.
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH:0]   dif_w;
  logic             add_ov, sub_ov, less_s, less_u;
  logic [WIDTH-1:0] simple_res;
  logic             simple_ovf;

  always_comb begin
    sum_w      = a_q + b_q;
    dif_w      = {1'b0, a_q} - {1'b0, b_q};
    add_ov     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
    sub_ov     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
    less_s     = sub_ov ^ dif_w[WIDTH-1];
    less_u     = dif_w[WIDTH];  // borrow out of the unsigned subtract
    simple_res = '0;
    simple_ovf = 1'b0;
    case (op)
      4'b0000: begin
        simple_res = sum_w;
        simple_ovf = add_ov;
      end
      4'b0001, 4'b1000, 4'b1001: simple_res = sum_w;
      4'b0010: begin
        simple_res = dif_w[WIDTH-1:0];
        simple_ovf = sub_ov;
      end
      4'b0011: simple_res = dif_w[WIDTH-1:0];
      4'b0100: simple_res = a_q & b_q;
      4'b0101: simple_res = a_q | b_q;
      4'b0110: simple_res = a_q ^ b_q;
      4'b0111: simple_res = ~(a_q | b_q);
      4'b1010: simple_res = {{(WIDTH-1){1'b0}}, less_s};
      4'b1011: simple_res = {{(WIDTH-1){1'b0}}, less_u};
      default: ;
    endcase
  end

  // Operand magnitudes at accept; signed variants have ALUctr[0] == 0.
  logic             in_signed;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;

  always_comb begin
    in_signed = ~ALUctr[0];
    in_mag_a  = (in_signed && A[WIDTH-1]) ? -A : A;
    in_mag_b  = (in_signed && B[WIDTH-1]) ? -B : B;
  end

  // One iteration step for each of mul and div.
  logic [WIDTH:0] mul_sum, rem_sh, trial;

  always_comb begin
    mul_sum = acc_q + (lo_q[0] ? {1'b0, mag_a_q} : '0);
    rem_sh  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, mag_b_q};
  end

  // Sign correction and special cases once the loop has finished.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_res, fin_hi;

  always_comb begin
    prod = {acc_q[WIDTH-1:0], lo_q};
    if (qneg_q) prod = -prod;
    if (op[1]) begin
      if (b_q == '0) begin
        // Divide by zero: all-ones quotient, dividend passed through as remainder.
        fin_res = '1;
        fin_hi  = a_q;
      end else begin
        fin_res = qneg_q ? -lo_q : lo_q;
        fin_hi  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end else begin
      fin_res = prod[WIDTH-1:0];
      fin_hi  = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      ctr_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            ctr_q <= ALUctr;
            if (ALUctr[3:2] == 2'b11) begin
              mag_a_q <= in_mag_a;
              mag_b_q <= in_mag_b;
              acc_q   <= '0;
              lo_q    <= ALUctr[1] ? in_mag_a : in_mag_b;
              cnt_q   <= CntW'(WIDTH - 1);
              qneg_q  <= in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
              rneg_q  <= in_signed & A[WIDTH-1];
              state_q <= StBusy;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          res_q   <= simple_res;
          hi_q    <= '0;
          zero_q  <= (simple_res == '0);
          ovfl_q  <= simple_ovf;
          state_q <= StDone;
        end
        StBusy: begin
          if (op[1]) begin
            if (!trial[WIDTH]) begin
              acc_q <= trial;
              lo_q  <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_q <= rem_sh;
              lo_q  <= {lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_q <= {1'b0, mul_sum[WIDTH:1]};
            lo_q  <= {mul_sum[0], lo_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) state_q <= StFin;
        end
        StFin: begin
          res_q   <= fin_res;
          hi_q    <= fin_hi;
          zero_q  <= (fin_res == '0);
          ovfl_q  <= 1'b0;
          state_q <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Res       = res_q;
  assign Hi        = hi_q;
  assign Zero      = zero_q;
  assign Overfl    = ovfl_q;

endmodule

// File: tb/tb_alu_mc_seq.sv
module tb_alu_mc_seq;

  logic clk;
  logic rst;

  logic        iv32, ir32, ov32, or32, z32, of32;
  logic [31:0] a32, b32, res32, hi32;
  logic [3:0]  ctr32;

  logic        iv8, ir8, ov8, or8, z8, of8;
  logic [7:0]  a8, b8, res8, hi8;
  logic [3:0]  ctr8;

  int errors = 0;
  int checks = 0;

  alu_mc_seq #(.WIDTH(32), .CTR_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32),
    .ALUctr(ctr32), .out_valid(ov32), .out_ready(or32), .Res(res32), .Hi(hi32),
    .Zero(z32), .Overfl(of32)
  );

  alu_mc_seq #(.WIDTH(8), .CTR_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .ALUctr(ctr8), .out_valid(ov8), .out_ready(or8), .Res(res8), .Hi(hi8),
    .Zero(z8), .Overfl(of8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic on w-bit values.
  function automatic void model(input int w, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output logic [31:0] hi, output logic ovf);
    longint mask, ua, ub, sa, sb, s;
    mask = (longint'(1) <<< w) - 1;
    ua   = longint'({32'b0, a}) & mask;
    ub   = longint'({32'b0, b}) & mask;
    sa   = ua[w-1] ? ua - (mask + 1) : ua;
    sb   = ub[w-1] ? ub - (mask + 1) : ub;
    hi   = '0;
    ovf  = 1'b0;
    s    = 0;
    case (op)
      4'h0, 4'h1, 4'h8, 4'h9: begin
        s   = sa + sb;
        ovf = (op == 4'h0) && (s > (mask >> 1) || s < -(mask >> 1) - 1);
      end
      4'h2, 4'h3: begin
        s   = sa - sb;
        ovf = (op == 4'h2) && (s > (mask >> 1) || s < -(mask >> 1) - 1);
      end
      4'h4: s = ua & ub;
      4'h5: s = ua | ub;
      4'h6: s = ua ^ ub;
      4'h7: s = ~(ua | ub);
      4'hA: s = (sa < sb) ? 1 : 0;
      4'hB: s = (ua < ub) ? 1 : 0;
      4'hC: begin
        s  = sa * sb;
        hi = 32'((s >>> w) & mask);
      end
      4'hD: begin
        s  = ua * ub;
        hi = 32'((s >> w) & mask);
      end
      4'hE: begin
        if (sb == 0) begin
          s  = mask;
          hi = 32'(ua);
        end else begin
          s  = sa / sb;
          hi = 32'((sa % sb) & mask);
        end
      end
      default: begin
        if (ub == 0) begin
          s  = mask;
          hi = 32'(ua);
        end else begin
          s  = ua / ub;
          hi = 32'(ua % ub);
        end
      end
    endcase
    res = 32'(s & mask);
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1 << (w - 1);
      2:       return mask;
      3:       return 32'h1;
      default: return $urandom & mask;
    endcase
  endfunction

  // Issue one op, wait (bounded) for out_valid, capture, then hand shake it off.
  // lat is the cycle count from the accept edge, -1 on timeout.
  task automatic run_op(input bit w8, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output logic [31:0] r,
                        output logic [31:0] h, output logic z, output logic o);
    if (w8) begin
      iv8 = 1'b1; ctr8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv32 = 1'b1; ctr32 = op; a32 = a; b32 = b;
    end
    @(posedge clk);
    @(negedge clk);
    iv8  = 1'b0;
    iv32 = 1'b0;
    lat  = 0;
    while (!(w8 ? ov8 : ov32) && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!(w8 ? ov8 : ov32)) lat = -1;
    r = w8 ? {24'b0, res8} : res32;
    h = w8 ? {24'b0, hi8} : hi32;
    z = w8 ? z8 : z32;
    o = w8 ? of8 : of32;
    or8  = w8;
    or32 = !w8;
    @(posedge clk);
    @(negedge clk);
    or8  = 1'b0;
    or32 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", ir32, ov32);
    end
    checks++;
    if (res32 !== 32'h0 || hi32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: Res=%h Hi=%h, want 0 0", res32, hi32);
    end
    checks++;
    if (z32 !== 1'b0 || of32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: Zero=%b Overfl=%b, want 0 0", z32, of32);
    end
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || res8 !== 8'h0 || hi8 !== 8'h0) begin
      errors++;
      $display("FAIL reset_w8: in_ready=%b out_valid=%b Res=%h Hi=%h, want 1 0 00 00",
               ir8, ov8, res8, hi8);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res, hi;
    logic        ovf;
  } vec_t;

  task automatic test_directed();
    vec_t        v[12];
    int          lat, want_lat;
    logic [31:0] r, h;
    logic        z, o;
    v[0]  = '{4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 1'b1};
    v[1]  = '{4'h1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 1'b0};
    v[2]  = '{4'h2, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0};
    v[3]  = '{4'hA, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0};
    v[4]  = '{4'hB, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0};
    v[5]  = '{4'hC, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0};
    v[6]  = '{4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    v[7]  = '{4'hE, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    v[8]  = '{4'hF, 32'h9, 32'h0, 32'hFFFF_FFFF, 32'h9, 1'b0};
    v[9]  = '{4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0};
    v[10] = '{4'hE, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    v[11] = '{4'h2, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, v[i].op, v[i].a, v[i].b, lat, r, h, z, o);
      want_lat = (v[i].op[3:2] == 2'b11) ? 33 : 1;
      checks++;
      if (lat != want_lat) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, want_lat);
      end
      checks++;
      if (r !== v[i].res || h !== v[i].hi) begin
        errors++;
        $display("FAIL dir%0d_result: Res=%h Hi=%h want %h %h", i, r, h, v[i].res, v[i].hi);
      end
      checks++;
      if (z !== (v[i].res == 32'h0) || o !== v[i].ovf) begin
        errors++;
        $display("FAIL dir%0d_flags: Zero=%b Overfl=%b want %b %b", i, z, o,
                 (v[i].res == 32'h0), v[i].ovf);
      end
    end
  endtask

  task automatic test_random(input bit w8, input int n);
    int          lat, want_lat, w;
    logic [3:0]  op;
    logic [31:0] a, b, r, h, er, eh;
    logic        z, o, eo;
    w = w8 ? 8 : 32;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick(w);
      b  = pick(w);
      model(w, op, a, b, er, eh, eo);
      want_lat = (op[3:2] == 2'b11) ? w + 1 : 1;
      run_op(w8, op, a, b, lat, r, h, z, o);
      checks++;
      if (lat != want_lat || r !== er || h !== eh || z !== (er == 32'h0) || o !== eo) begin
        errors++;
        $display("FAIL rand_w%0d op=%h a=%h b=%h: lat=%0d Res=%h Hi=%h Z=%b OV=%b want %0d %h %h %b %b",
                 w, op, a, b, lat, r, h, z, o, want_lat, er, eh, (er == 32'h0), eo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [31:0] r, h, er, eh;
    logic        z, o, eo;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, 4'h1, 32'(i), 32'h10, lat, r, h, z, o);
      model(32, 4'h1, 32'(i), 32'h10, er, eh, eo);
      checks++;
      if (ir32 !== 1'b1 || ov32 !== 1'b0 || r !== er || lat != 1) begin
        errors++;
        $display("FAIL b2b%0d: in_ready=%b out_valid=%b Res=%h lat=%0d want 1 0 %h 1",
                 i, ir32, ov32, r, lat, er);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] er, eh;
    logic        eo;
    model(32, 4'h6, 32'hA5A5_0F0F, 32'h0FF0_1234, er, eh, eo);
    iv32 = 1'b1; ctr32 = 4'h6; a32 = 32'hA5A5_0F0F; b32 = 32'h0FF0_1234;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ov32 !== 1'b1 || res32 !== er) begin
      errors++;
      $display("FAIL bp_first: out_valid=%b Res=%h want 1 %h", ov32, res32, er);
    end
    for (int i = 0; i < 5; i++) begin
      iv32 = 1'b1; ctr32 = 4'h0; a32 = $urandom; b32 = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ov32 !== 1'b1 || ir32 !== 1'b0 || res32 !== er || hi32 !== 32'h0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b Res=%h Hi=%h want 1 0 %h 0",
                 i, ov32, ir32, res32, hi32, er);
      end
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or32 = 1'b0;
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", ir32, ov32);
    end
  endtask

  // out_ready held high from before accept: must not shorten the op.
  task automatic test_early_ready();
    int          lat;
    logic [31:0] er, eh;
    logic        eo;
    model(32, 4'hC, 32'h1234_5678, 32'hFEDC_BA98, er, eh, eo);
    or32 = 1'b1;
    iv32 = 1'b1; ctr32 = 4'hC; a32 = 32'h1234_5678; b32 = 32'hFEDC_BA98;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    lat  = 0;
    while (!ov32 && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 33 || res32 !== er || hi32 !== eh) begin
      errors++;
      $display("FAIL early_ready: lat=%0d Res=%h Hi=%h want 33 %h %h", lat, res32, hi32, er, eh);
    end
    @(posedge clk);
    @(negedge clk);
    or32 = 1'b0;
    checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      errors++;
      $display("FAIL early_ready_drop: out_valid=%b in_ready=%b want 0 1", ov32, ir32);
    end
  endtask

  task automatic test_reset_busy();
    int          lat;
    logic [31:0] r, h;
    logic        z, o;
    run_op(1'b0, 4'h0, 32'h1, 32'h2, lat, r, h, z, o);
    iv32 = 1'b1; ctr32 = 4'hF; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0 || res32 !== 32'h0 || hi32 !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy: in_ready=%b out_valid=%b Res=%h Hi=%h want 1 0 0 0",
               ir32, ov32, res32, hi32);
    end
    run_op(1'b0, 4'hF, 32'd100, 32'd7, lat, r, h, z, o);
    checks++;
    if (lat != 33 || r !== 32'd14 || h !== 32'd2) begin
      errors++;
      $display("FAIL rst_recover: lat=%0d Res=%h Hi=%h want 33 e 2", lat, r, h);
    end
    // Reset while a result is waiting in DONE.
    iv32 = 1'b1; ctr32 = 4'h5; a32 = 32'h0F; b32 = 32'hF0;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1 || res32 !== 32'h0) begin
      errors++;
      $display("FAIL rst_done: out_valid=%b in_ready=%b Res=%h want 0 1 0", ov32, ir32, res32);
    end
  endtask

  task automatic test_width8();
    int          lat;
    logic [31:0] r, h;
    logic        z, o;
    run_op(1'b1, 4'hD, 32'hFF, 32'hFF, lat, r, h, z, o);
    checks++;
    if (lat != 9 || r !== 32'h01 || h !== 32'hFE) begin
      errors++;
      $display("FAIL w8_multu: lat=%0d Res=%h Hi=%h want 9 01 fe", lat, r, h);
    end
    test_random(1'b1, 60);
  endtask

  initial begin
    rst  = 1'b1;
    iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; ctr32 = '0;
    iv8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0; ctr8  = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_early_ready();
    test_reset_busy();
    test_random(1'b0, 300);
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
